// File: rtl/riscv_pkg.sv
// Shared RISC-V platform constants: CLINT register offsets, reset values and payload types.
package riscv_pkg;

    localparam int unsigned CLINT_ADDR_W = 16;
    localparam int unsigned CLINT_DATA_W = 32;
    localparam int unsigned MTIME_W      = 64;

    localparam logic [CLINT_ADDR_W-1:0] CLINT_MSIP_OFF        = 16'h0000;
    localparam logic [CLINT_ADDR_W-1:0] CLINT_MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [CLINT_ADDR_W-1:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [CLINT_ADDR_W-1:0] CLINT_MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [CLINT_ADDR_W-1:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;

    localparam logic [MTIME_W-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_TIME_LO,
        REG_TIME_HI,
        REG_NONE
    } clint_reg_e;

    typedef struct packed {
        logic [CLINT_DATA_W-1:0] rdata;
        logic                    err;
    } clint_rsp_t;

    // Word-aligned decode; byte-offset bits [1:0] never select a register.
    function automatic clint_reg_e clint_decode(input logic [CLINT_ADDR_W-1:0] addr);
        logic [CLINT_ADDR_W-1:0] word;
        word = addr & ~CLINT_ADDR_W'(3);
        case (word)
            CLINT_MSIP_OFF:        return REG_MSIP;
            CLINT_MTIMECMP_LO_OFF: return REG_CMP_LO;
            CLINT_MTIMECMP_HI_OFF: return REG_CMP_HI;
            CLINT_MTIME_LO_OFF:    return REG_TIME_LO;
            CLINT_MTIME_HI_OFF:    return REG_TIME_HI;
            default:               return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; resets to zero.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/clint.sv
// Core-local interruptor: msip, prescaled 64-bit mtime/mtimecmp, timer/soft/external irq outputs.
module clint
    import riscv_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [CLINT_ADDR_W-1:0] req_addr,
    input  logic [CLINT_DATA_W-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic [CLINT_DATA_W-1:0] rsp_rdata,
    output logic                    rsp_err,
    input  logic                    extern_irq_async,
    output logic                    extern_irq,
    output logic                    soft_irq,
    output logic                    timer_irq
);

    localparam int unsigned            PRESC_W    = 8;
    localparam logic [PRESC_W-1:0]     PRESC_LAST = PRESC_W'(PRESCALE - 1);

    logic                 w_accept;
    logic                 w_wr;
    logic                 w_tick;
    clint_reg_e           w_reg;
    clint_rsp_t           w_rsp;
    logic [MTIME_W-1:0]   w_mtime_nxt;
    logic [PRESC_W-1:0]   w_presc_nxt;

    logic                 r_rsp_valid;
    clint_rsp_t           r_rsp;
    logic [MTIME_W-1:0]   r_mtime;
    logic [MTIME_W-1:0]   r_mtimecmp;
    logic [PRESC_W-1:0]   r_presc;
    logic                 r_msip;
    logic                 r_timer_irq;

    assign req_ready = ~r_rsp_valid;
    assign w_accept  = req_valid & ~r_rsp_valid;
    assign w_wr      = w_accept & req_we;
    assign w_reg     = clint_decode(req_addr);
    assign w_tick    = (r_presc == PRESC_LAST);

    // Response payload from pre-update register values; writes return zero data.
    always_comb begin
        w_rsp = '0;
        case (w_reg)
            REG_MSIP:    w_rsp.rdata = {{(CLINT_DATA_W-1){1'b0}}, r_msip};
            REG_CMP_LO:  w_rsp.rdata = r_mtimecmp[31:0];
            REG_CMP_HI:  w_rsp.rdata = r_mtimecmp[63:32];
            REG_TIME_LO: w_rsp.rdata = r_mtime[31:0];
            REG_TIME_HI: w_rsp.rdata = r_mtime[63:32];
            default:     w_rsp.err   = 1'b1;
        endcase
        if (req_we) begin
            w_rsp.rdata = '0;
        end
    end

    // A software write to either mtime half pre-empts the tick and restarts the prescaler.
    always_comb begin
        w_mtime_nxt = r_mtime;
        w_presc_nxt = r_presc + PRESC_W'(1);
        if (w_wr && (w_reg == REG_TIME_LO)) begin
            w_mtime_nxt[31:0] = req_wdata;
            w_presc_nxt       = '0;
        end else if (w_wr && (w_reg == REG_TIME_HI)) begin
            w_mtime_nxt[63:32] = req_wdata;
            w_presc_nxt        = '0;
        end else if (w_tick) begin
            w_mtime_nxt = r_mtime + 64'd1;
            w_presc_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
            r_mtime     <= '0;
            r_presc     <= '0;
            r_mtimecmp  <= MTIMECMP_RST;
            r_msip      <= 1'b0;
            r_timer_irq <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            r_rsp       <= w_accept ? w_rsp : '0;
            r_mtime     <= w_mtime_nxt;
            r_presc     <= w_presc_nxt;
            r_timer_irq <= (r_mtime >= r_mtimecmp);
            if (w_wr) begin
                case (w_reg)
                    REG_MSIP:   r_msip             <= req_wdata[0];
                    REG_CMP_LO: r_mtimecmp[31:0]   <= req_wdata;
                    REG_CMP_HI: r_mtimecmp[63:32]  <= req_wdata;
                    default:    ;
                endcase
            end
        end
    end

    sync_2ff #(
        .WIDTH(1)
    ) u_ext_sync (
        .clk (clk),
        .rst (reset),
        .i_d (extern_irq_async),
        .o_q (extern_irq)
    );

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp.rdata;
    assign rsp_err   = r_rsp.err;
    assign soft_irq  = r_msip;
    assign timer_irq = r_timer_irq;

endmodule
